// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: three-state fetch FSM, PC, one-entry pending buffer and IF/ID register.
// Optional opcode legality flag enabled by defining IF_OPCODE_CHECK_EN.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc4,
  output logic        if_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic        req_q;
  logic [31:0] pend_instr_p0;
  logic [31:0] pend_pc4_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic        unused_tgt;

  // Redirect targets are forced word-aligned, so the low bits never matter.
  assign unused_tgt = ^branch_target[1:0];
  assign pc_inc     = pc + 32'd4;

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign if_valid  = vld_p1;
  assign if_instr  = instr_p1;
  assign if_pc4    = pc4_p1;
  assign if_opcode = instr_p1[31:26];

`ifdef IF_OPCODE_CHECK_EN
  logic ill_p1;

  function automatic logic opcode_illegal(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h23, 6'h2B, 6'h21,
      6'h25, 6'h0C, 6'h0D, 6'h04: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

  assign if_illegal = ill_p1;
`else
  assign if_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      req_q         <= 1'b0;
      pend_instr_p0 <= '0;
      pend_pc4_p0   <= '0;
      instr_p1      <= '0;
      pc4_p1        <= '0;
      vld_p1        <= 1'b0;
`ifdef IF_OPCODE_CHECK_EN
      ill_p1        <= 1'b0;
`endif
    end else if (branch_taken) begin
      // Redirect beats stall and ack: in-flight and pending words are dropped.
      state  <= REQ;
      req_q  <= 1'b1;
      pc     <= {branch_target[31:2], 2'b00};
      vld_p1 <= 1'b0;
`ifdef IF_OPCODE_CHECK_EN
      ill_p1 <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem_ack && !stall) begin
            // ---- stage p1: IF/ID capture ----
            instr_p1 <= imem_rdata;
            pc4_p1   <= pc_inc;
            vld_p1   <= 1'b1;
`ifdef IF_OPCODE_CHECK_EN
            ill_p1   <= opcode_illegal(imem_rdata[31:26]);
`endif
            pc       <= pc_inc;
          end else if (imem_ack) begin
            // ---- stage p0: park the word while decode is stalled ----
            pend_instr_p0 <= imem_rdata;
            pend_pc4_p0   <= pc_inc;
            pc            <= pc_inc;
            state         <= HOLD;
            req_q         <= 1'b0;
          end else if (!stall) begin
            vld_p1 <= 1'b0;
`ifdef IF_OPCODE_CHECK_EN
            ill_p1 <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_p1 <= pend_instr_p0;
            pc4_p1   <= pend_pc4_p0;
            vld_p1   <= 1'b1;
`ifdef IF_OPCODE_CHECK_EN
            ill_p1   <= opcode_illegal(pend_instr_p0[31:26]);
`endif
            state    <= REQ;
            req_q    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random ack/stall/branch traffic
// compared cycle by cycle against a transaction-level model of the fetch rules.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc4;
  logic        if_illegal;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_opcode;
  logic [31:0] w_pc4;
  logic        w_illegal;

  int errors = 0;
  int checks = 0;

`ifdef IF_OPCODE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
    .if_pc4(if_pc4), .if_illegal(if_illegal)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(w_valid), .if_instr(w_instr), .if_opcode(w_opcode),
    .if_pc4(w_pc4), .if_illegal(w_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: "waiting" = one cycle after reset, "fetching" = requesting,
  // "parked" = a word is buffered behind a stalled decode.
  int          phase;
  logic [31:0] m_pc, m_instr, m_pc4, p_instr, p_pc4;
  bit          m_valid, m_ill;

  function automatic bit illegal_op(input logic [5:0] op);
    logic [5:0] legal [9] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h21, 6'h25, 6'h0C, 6'h0D, 6'h04};
    if (!CHK_EN) return 1'b0;
    foreach (legal[i]) if (legal[i] == op) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    phase = 0; m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_valid = 0; m_ill = 0;
    p_instr = '0; p_pc4 = '0;
  endtask

  task automatic model_clock();
    if (branch_taken) begin
      m_pc = branch_target & ~32'h3; m_valid = 0; m_ill = 0; phase = 1;
    end else if (phase == 0) begin
      phase = 1;
    end else if (phase == 1) begin
      if (imem_ack && !stall) begin
        m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1;
        m_ill = illegal_op(imem_rdata[31:26]); m_pc = m_pc + 4;
      end else if (imem_ack) begin
        p_instr = imem_rdata; p_pc4 = m_pc + 4; m_pc = m_pc + 4; phase = 2;
      end else if (!stall) begin
        m_valid = 0; m_ill = 0;
      end
    end else if (!stall) begin
      m_instr = p_instr; m_pc4 = p_pc4; m_valid = 1;
      m_ill = illegal_op(p_instr[31:26]); phase = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".req"},     {31'b0, imem_req},   {31'b0, phase == 1});
    check({tag, ".addr"},    imem_addr,           m_pc);
    check({tag, ".valid"},   {31'b0, if_valid},   {31'b0, m_valid});
    check({tag, ".instr"},   if_instr,            m_instr);
    check({tag, ".opcode"},  {26'b0, if_opcode},  {26'b0, m_instr[31:26]});
    check({tag, ".pc4"},     if_pc4,              m_pc4);
    check({tag, ".illegal"}, {31'b0, if_illegal}, {31'b0, m_ill});
  endtask

  task automatic cycle(input string tag, input bit a, input bit s, input bit b,
                       input logic [31:0] t, input logic [31:0] d);
    imem_ack = a; stall = s; branch_taken = b; branch_target = t; imem_rdata = d;
    @(posedge clk);
    if (rst) model_reset(); else model_clock();
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset state, no clock edge needed
    #2;
    compare_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch from 0 with rdata = addr; wrap instance runs alongside
    cycle("seq0", 1, 0, 0, 0, m_pc);
    check("seq0.valid_low", {31'b0, if_valid}, 32'd0);
    check("wrap.addr0", w_addr, 32'hFFFF_FFFC);
    cycle("seq1", 1, 0, 0, 0, m_pc);
    check("seq1.pc4", if_pc4, 32'd4);
    check("wrap.addr1", w_addr, 32'h0000_0000);
    check("wrap.pc4", w_pc4, 32'h0000_0000);
    check("wrap.valid", {31'b0, w_valid}, 32'd1);
    cycle("seq2", 1, 0, 0, 0, m_pc);
    check("seq2.pc4", if_pc4, 32'd8);
    check("wrap.addr2", w_addr, 32'h0000_0004);
    for (int i = 0; i < 8 && m_pc != 32'h10; i++) cycle("seq", 1, 0, 0, 0, m_pc);
    check("at_0x10", imem_addr, 32'h10);

    // Stall coincident with ack at 0x10, held for three cycles
    cycle("stall0", 1, 1, 0, 0, m_pc);
    check("stall0.req", {31'b0, imem_req}, 32'd0);
    check("stall0.pc4_held", if_pc4, 32'h10);
    cycle("stall1", 1, 1, 0, 0, 32'hDEAD_BEEF);
    cycle("stall2", 1, 1, 0, 0, 32'hDEAD_BEEF);
    cycle("unstall", 1, 0, 0, 0, 32'hDEAD_BEEF);
    check("unstall.instr", if_instr, 32'h10);
    check("unstall.pc4", if_pc4, 32'h14);
    check("unstall.addr", imem_addr, 32'h14);

    // Branch while parked and stalled discards the pending word
    cycle("park", 1, 1, 0, 0, m_pc);
    cycle("branch", 0, 1, 1, 32'h0000_0103, 32'h0);
    check("branch.addr", imem_addr, 32'h100);
    check("branch.valid", {31'b0, if_valid}, 32'd0);
    cycle("post_br", 1, 0, 0, 0, m_pc);
    check("post_br.instr", if_instr, 32'h100);

    // Opcode legality flag
    cycle("ill0", 1, 0, 0, 0, 32'hFC00_0000);
    check("ill0.flag", {31'b0, if_illegal}, {31'b0, CHK_EN});
    cycle("ill1", 1, 0, 0, 0, 32'h2000_0001);
    check("ill1.flag", {31'b0, if_illegal}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d[31:26] = 6'h23;
      cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom, d);
    end

    // Asynchronous reset mid-request with no ack
    cycle("pre_rst", 0, 0, 0, 0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    cycle("restart0", 1, 0, 0, 0, m_pc);
    check("restart0.addr", imem_addr, 32'h0);
    cycle("restart1", 1, 0, 0, 0, m_pc);
    cycle("restart2", 1, 0, 0, 0, m_pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned address of first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address, always equal to internal PC.
REQ-006 imem_ack  input  1  memory returns imem_rdata for the current imem_addr this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-008 stall  input  1  decode stage cannot accept a new instruction; IF/ID outputs must hold.
REQ-009 branch_taken  input  1  single-cycle redirect pulse (Branch AND zero from downstream).
REQ-010 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-011 if_valid  output  1  IF/ID register holds a live instruction.
REQ-012 if_instr  output  32  registered instruction word.
REQ-013 if_opcode  output  6  if_instr[31:26], drives the decode control unit.
REQ-014 if_pc4  output  32  registered address of if_instr plus 4.
REQ-015 if_illegal  output  1  registered opcode-check flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-017 imem_req SHALL be 1 in REQ only; 0 in IDLE and HOLD.
REQ-018 In REQ with imem_ack=1, stall=0, branch_taken=0: if_instr<=imem_rdata, if_pc4<=PC+4, if_valid<=1, PC<=PC+4, stay REQ; sustained throughput one instruction per cycle.
REQ-019 In REQ with imem_ack=0 and no branch: if_valid<=0 unless stall=1 (then IF/ID holds); PC unchanged.
REQ-020 In REQ with imem_ack=1, stall=1: word and PC+4 SHALL be captured into a one-entry pending buffer, PC<=PC+4, go HOLD; IF/ID outputs unchanged.
REQ-021 In HOLD with stall=1: everything holds; on stall=0: pending buffer moves to IF/ID with if_valid<=1, go REQ (next fetch the following cycle).
REQ-022 While stall=1 in any state, if_valid/if_instr/if_pc4/if_illegal SHALL not change (except on branch, REQ-023).
REQ-023 branch_taken=1 SHALL take priority over stall and imem_ack in every state: PC<={branch_target[31:2],2'b00}, if_valid<=0, pending buffer discarded, any same-cycle imem_rdata discarded, next state REQ; first redirected instruction reaches IF/ID no earlier than 2 cycles after the pulse.
REQ-024 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000 without error.
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 if_opcode SHALL be combinationally if_instr[31:26], no extra latency.

Reset
REQ-027 On rst=1, immediately and independent of clk: state=IDLE, PC=RESET_PC, imem_req=0, if_valid=0, if_instr=0 (NOP), if_pc4=0, if_illegal=0, pending buffer empty.
REQ-028 Reset asserted mid-fetch or in HOLD SHALL abandon the transaction; the first request after release uses RESET_PC.

Configuration
REQ-029 Macro IF_OPCODE_CHECK_EN defined: if_illegal SHALL be registered alongside if_instr, 1 when opcode not in {6'h00,6'h08,6'h23,6'h2B,6'h21,6'h25,6'h0C,6'h0D,6'h04}, and cleared with if_valid on flush.
REQ-030 Macro IF_OPCODE_CHECK_EN undefined: if_illegal SHALL be constant 0 and no check logic synthesised; port list unchanged.

Verification
REQ-031 Reset release, imem_ack always 1, rdata=addr -> imem_addr 0,4,8,...; if_valid rises 2 cycles after release, if_pc4=4,8,12 in consecutive cycles.
REQ-032 stall=1 for 3 cycles coincident with an ack at addr 0x10 -> IF/ID holds prior word, state HOLD, imem_req=0; after stall drop word from 0x10 appears with if_pc4=0x14, next address 0x14.
REQ-033 branch_taken=1, branch_target=0x0000_0103 while stall=1 and in HOLD -> next imem_addr=0x100, if_valid=0 next cycle, pending word never appears.
REQ-034 RESET_PC=32'hFFFF_FFFC, ack=1 -> imem_addr sequence FFFF_FFFC, 0000_0000, 0000_0004; if_pc4 of first word = 0.
REQ-035 With IF_OPCODE_CHECK_EN, fetch 32'hFC00_0000 then 32'h2000_0001 -> if_illegal 1 then 0; without macro -> if_illegal 0 throughout.
REQ-036 rst pulsed asynchronously mid-REQ with imem_ack=0 -> outputs reach reset values before next clk edge; fetch restarts at RESET_PC.
